ldm_stm_sequencer: RTL and testbench

//  Multi-cycle initiator for the register bank during ARM LDM/STM (block transfer).
//  - Walks a 16-bit register list.
//  - Drives the bank's read/write selects, mapped to the banked index for the current mode.
//  - Moves one word per memory handshake, then optionally writes the updated base back.
//  - Sits between the decode/execute stage and the register bank / data-memory port.

---
 rtl/arm_regs_pkg.sv | 32 +++
 rtl/bank_index_map.sv | 32 +++
 rtl/ldm_stm_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_regs_pkg.sv
// Shared register-bank definitions: CPSR mode encodings, banked register
// indices and the LDM/STM sequencer state type.
package arm_regs_pkg;

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_UND = 5'b11011;

  localparam logic [4:0] IDX_CPSR     = 5'd16;
  localparam logic [4:0] IDX_R13_SVC  = 5'd17;
  localparam logic [4:0] IDX_R14_SVC  = 5'd18;
  localparam logic [4:0] IDX_SPSR_SVC = 5'd19;
  localparam logic [4:0] IDX_R13_ABT  = 5'd20;
  localparam logic [4:0] IDX_R14_ABT  = 5'd21;
  localparam logic [4:0] IDX_SPSR_ABT = 5'd22;
  localparam logic [4:0] IDX_R13_IRQ  = 5'd23;
  localparam logic [4:0] IDX_R14_IRQ  = 5'd24;
  localparam logic [4:0] IDX_SPSR_IRQ = 5'd25;
  localparam logic [4:0] IDX_R13_UND  = 5'd26;
  localparam logic [4:0] IDX_R14_UND  = 5'd27;
  localparam logic [4:0] IDX_SPSR_UND = 5'd28;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/bank_index_map.sv
// Maps an architectural register number to its register-bank index for the
// given CPSR mode. Only r13/r14 are banked; user_bank forces the user view.
module bank_index_map
  import arm_regs_pkg::*;
(
  input  logic [4:0] mode,
  input  logic       user_bank,
  input  logic [3:0] reg_num,
  output logic [4:0] idx
);

  logic is_r14;
  logic banked;

  assign is_r14 = (reg_num == 4'd14);
  assign banked = !user_bank && ((reg_num == 4'd13) || is_r14);

  // Select the banked r13/r14 slot for privileged modes, identity otherwise
  always_comb begin
    idx = {1'b0, reg_num};
    if (banked) begin
      case (mode)
        MODE_SVC: idx = IDX_R13_SVC + {4'b0, is_r14};
        MODE_ABT: idx = IDX_R13_ABT + {4'b0, is_r14};
        MODE_IRQ: idx = IDX_R13_IRQ + {4'b0, is_r14};
        MODE_UND: idx = IDX_R13_UND + {4'b0, is_r14};
        default:  idx = {1'b0, reg_num};
      endcase
    end
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: walks the register list, moves one word
// per memory handshake and optionally writes the updated base back.
// Optional feature macro: MEM_ABORT_EN (adds mem_abort input / aborted output).
// Each word takes at least two cycles: the request cycle(s) ending in mem_ack,
// then one idle cycle before the next request.
module ldm_stm_sequencer
  import arm_regs_pkg::*;
#(
  parameter int N_REGS = 29,
  parameter int WORD_B = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        is_load,
  input  logic                        up,
  input  logic                        pre,
  input  logic                        writeback,
  input  logic                        user_bank,
  input  logic [4:0]                  mode,
  input  logic [3:0]                  base_reg,
  input  logic [31:0]                 base_val,
  input  logic [15:0]                 reg_list,
  output logic [$clog2(N_REGS)-1:0]   rd_sel,
  input  logic [31:0]                 rd_data,
  output logic                        wr_en,
  output logic [$clog2(N_REGS)-1:0]   wr_sel,
  output logic [31:0]                 wr_data,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [31:0]                 mem_addr,
  output logic [31:0]                 mem_wdata,
  input  logic [31:0]                 mem_rdata,
  input  logic                        mem_ack,
  output logic                        busy,
  output logic                        done
`ifdef MEM_ABORT_EN
  ,
  input  logic                        mem_abort,
  output logic                        aborted
`endif
);

  localparam logic [31:0] STEP = 32'(WORD_B);

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'b0, v[i]};
    return c;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) r = 4'(i);
    return r;
  endfunction

  seq_state_t  state_q, state_d;
  logic        gap_q;
  logic [15:0] list_q;
  logic [31:0] addr_q;
  logic [31:0] final_q;
  logic        load_q;
  logic        wb_q;
  logic        user_q;
  logic [4:0]  mode_q;
  logic [3:0]  base_reg_q;

  logic [31:0] span;
  logic [31:0] start_addr;
  logic [31:0] final_base;
  logic [15:0] list_rest;
  logic [3:0]  cur_reg;
  logic [3:0]  map_reg;
  logic [4:0]  map_idx;
  logic        req_active;
  logic        ack_hit;
  logic        abort_hit;

  assign span       = 32'(popcount16(reg_list)) * STEP;
  assign start_addr = up ? (pre ? base_val + STEP : base_val)
                         : (pre ? base_val - span : base_val - span + STEP);
  assign final_base = up ? base_val + span : base_val - span;
  assign list_rest  = list_q & (list_q - 16'd1);
  assign cur_reg    = lowest_set(list_q);
  assign map_reg    = (state_q == WB) ? base_reg_q : cur_reg;
  assign req_active = (state_q == XFER) && !gap_q;
  assign ack_hit    = req_active && mem_ack;

`ifdef MEM_ABORT_EN
  logic aborted_q;
  assign abort_hit = ack_hit && mem_abort;
  assign aborted   = aborted_q;
`else
  assign abort_hit = 1'b0;
`endif

  bank_index_map u_map (
    .mode      (mode_q),
    .user_bank (user_q),
    .reg_num   (map_reg),
    .idx       (map_idx)
  );

  // Control state: FSM, inter-word gap and abort flag (reset aborts a transfer)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gap_q   <= 1'b0;
`ifdef MEM_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gap_q   <= ack_hit;
`ifdef MEM_ABORT_EN
      if (state_q == IDLE && start) aborted_q <= 1'b0;
      else if (abort_hit)           aborted_q <= 1'b1;
`endif
    end
  end

  // Transfer context: latched on start, advanced on every completed word
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      list_q     <= reg_list;
      addr_q     <= start_addr;
      final_q    <= final_base;
      load_q     <= is_load;
      wb_q       <= writeback && !(is_load && reg_list[base_reg]);
      user_q     <= user_bank;
      mode_q     <= mode;
      base_reg_q <= base_reg;
    end else if (ack_hit) begin
      list_q <= list_rest;
      addr_q <= addr_q + STEP;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (reg_list == 16'd0) ? DONE : XFER;
      XFER: begin
        if (abort_hit)                        state_d = DONE;
        else if (ack_hit && list_rest == '0)  state_d = wb_q ? WB : DONE;
      end
      WB:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: bank and memory strobes per state, zero when idle
  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rd_sel    = '0;
    wr_en     = 1'b0;
    wr_sel    = '0;
    wr_data   = '0;
    if (state_q == XFER) begin
      mem_req  = req_active;
      mem_we   = req_active && !load_q;
      mem_addr = req_active ? addr_q : '0;
      if (!load_q) begin
        rd_sel    = map_idx;
        mem_wdata = req_active ? rd_data : '0;
      end else if (ack_hit && !abort_hit) begin
        wr_en   = 1'b1;
        wr_sel  = map_idx;
        wr_data = mem_rdata;
      end
    end else if (state_q == WB) begin
      wr_en   = 1'b1;
      wr_sel  = map_idx;
      wr_data = final_q;
    end
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed testbench for ldm_stm_sequencer (also covers MEM_ABORT_EN builds).
module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, is_load, up, pre, writeback, user_bank;
  logic [4:0]  mode;
  logic [3:0]  base_reg;
  logic [31:0] base_val;
  logic [15:0] reg_list;
  logic [4:0]  rd_sel;
  logic [31:0] rd_data;
  logic        wr_en;
  logic [4:0]  wr_sel;
  logic [31:0] wr_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        busy, done;
  logic        use_fixed;
  logic [31:0] fixed_rdata;
`ifdef MEM_ABORT_EN
  logic        mem_abort;
  logic        aborted;
  logic        aborted_at_done;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] addr_log[$];
  logic [31:0] rdsel_log[$];
  logic [31:0] wdata_log[$];
  logic [31:0] we_log[$];
  logic [31:0] wsel_log[$];
  logic [31:0] wdat_log[$];
  logic [31:0] bank [0:28];
  int          done_cyc;
  int          done_cnt;

  always #5 clk = ~clk;

  assign rd_data   = 32'hA000_0000 | {27'b0, rd_sel};
  assign mem_rdata = use_fixed ? fixed_rdata : {16'hC000, mem_addr[15:0]};

  ldm_stm_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_load   (is_load),
    .up        (up),
    .pre       (pre),
    .writeback (writeback),
    .user_bank (user_bank),
    .mode      (mode),
    .base_reg  (base_reg),
    .base_val  (base_val),
    .reg_list  (reg_list),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .done      (done)
`ifdef MEM_ABORT_EN
    ,
    .mem_abort (mem_abort),
    .aborted   (aborted)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_bank();
    for (int i = 0; i < 29; i++) bank[i] = 32'h5555_0000 | 32'(i);
  endtask

  // Present a start request for one cycle (deasserted inside run_op)
  task automatic start_op(input logic ld, input logic u, input logic p, input logic w,
                          input logic s, input logic [4:0] md, input logic [3:0] rn,
                          input logic [31:0] bv, input logic [15:0] lst);
    @(negedge clk);
    is_load = ld; up = u; pre = p; writeback = w; user_bank = s;
    mode = md; base_reg = rn; base_val = bv; reg_list = lst;
    start = 1'b1;
    addr_log.delete(); rdsel_log.delete(); wdata_log.delete(); we_log.delete();
    wsel_log.delete(); wdat_log.delete();
    done_cyc = -1; done_cnt = 0;
    @(posedge clk);
  endtask

  // Memory responder and observer: acks after ack_dly waiting cycles,
  // stops on done, after stop_after acks (if >0), or at the cycle budget.
  task automatic run_op(input int ack_dly, input int stop_after, input int abort_at);
    int wait_cnt;
    int acks;
    bit fin;
    wait_cnt = 0; acks = 0; fin = 0;
    for (int c = 1; c <= 200 && !fin; c++) begin
      @(negedge clk);
      start = 1'b0;
      mem_ack = 1'b0;
`ifdef MEM_ABORT_EN
      mem_abort = 1'b0;
`endif
      if (mem_req) begin
        if (wait_cnt == ack_dly) begin
          mem_ack = 1'b1;
          wait_cnt = 0;
`ifdef MEM_ABORT_EN
          if (acks + 1 == abort_at) mem_abort = 1'b1;
`endif
        end else wait_cnt++;
      end
      #1;
      if (mem_req && mem_ack) begin
        acks++;
        addr_log.push_back(mem_addr);
        rdsel_log.push_back(32'(rd_sel));
        wdata_log.push_back(mem_wdata);
        we_log.push_back(32'(mem_we));
      end
      if (wr_en) begin
        wsel_log.push_back(32'(wr_sel));
        wdat_log.push_back(wr_data);
        if (wr_sel < 5'd29) bank[wr_sel] = wr_data;
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
`ifdef MEM_ABORT_EN
        aborted_at_done = aborted;
`endif
        fin = 1;
      end
      if (stop_after > 0 && acks == stop_after) fin = 1;
      if (c == 200 && !fin) chk("run_op_timeout", 32'(c), 32'd0);
    end
    if (abort_at < 0) $display("unused abort_at");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_load = 1'b0; up = 1'b0; pre = 1'b0;
    writeback = 1'b0; user_bank = 1'b0; mode = 5'b10000; base_reg = 4'd0;
    base_val = '0; reg_list = '0; mem_ack = 1'b0; use_fixed = 1'b0;
    fixed_rdata = '0;
`ifdef MEM_ABORT_EN
    mem_abort = 1'b0;
`endif
    clear_bank();
    repeat (2) @(posedge clk);
    @(negedge clk);
    // reset state: all outputs zero even with nonzero rd_data
    chk("rst_ctrl", {27'b0, mem_req, mem_we, wr_en, busy, done}, 32'd0);
    chk("rst_addr", mem_addr | mem_wdata | wr_data, 32'd0);
    chk("rst_sel", {22'b0, rd_sel, wr_sel}, 32'd0);
    reset = 1'b0;

    // STMIA r2 usr, list r0,r1,r3, writeback
    start_op(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'b10000, 4'd2, 32'h100, 16'h000B);
    run_op(0, 0, 0);
    chk("stmia_nwords", 32'(addr_log.size()), 32'd3);
    chk("stmia_a0", addr_log[0], 32'h100);
    chk("stmia_a1", addr_log[1], 32'h104);
    chk("stmia_a2", addr_log[2], 32'h108);
    chk("stmia_rs0", rdsel_log[0], 32'd0);
    chk("stmia_rs1", rdsel_log[1], 32'd1);
    chk("stmia_rs2", rdsel_log[2], 32'd3);
    chk("stmia_wd2", wdata_log[2], 32'hA000_0003);
    chk("stmia_we", we_log[0], 32'd1);
    chk("stmia_nwr", 32'(wsel_log.size()), 32'd1);
    chk("stmia_wbsel", wsel_log[0], 32'd2);
    chk("stmia_wbval", wdat_log[0], 32'h10C);
    chk("stmia_donecyc", 32'(done_cyc), 32'd7);
    @(negedge clk);
    chk("stmia_idle", {30'b0, busy, done}, 32'd0);

    // LDMDB r13 svc, list r0,r1,r14
    clear_bank();
    start_op(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'b10011, 4'd13, 32'h200, 16'h4003);
    run_op(0, 0, 0);
    chk("ldmdb_a0", addr_log[0], 32'h1F4);
    chk("ldmdb_a1", addr_log[1], 32'h1F8);
    chk("ldmdb_a2", addr_log[2], 32'h1FC);
    chk("ldmdb_nwr", 32'(wsel_log.size()), 32'd4);
    chk("ldmdb_ws0", wsel_log[0], 32'd0);
    chk("ldmdb_ws1", wsel_log[1], 32'd1);
    chk("ldmdb_ws2", wsel_log[2], 32'd18);
    chk("ldmdb_wd2", wdat_log[2], 32'hC000_01FC);
    chk("ldmdb_wbsel", wsel_log[3], 32'd17);
    chk("ldmdb_wbval", wdat_log[3], 32'h1F4);
    chk("ldmdb_we", we_log[0], 32'd0);

    // Same LDMDB with user_bank forcing the user view
    clear_bank();
    start_op(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'b10011, 4'd13, 32'h200, 16'h4003);
    run_op(0, 0, 0);
    chk("ldmdb_s_ws2", wsel_log[2], 32'd14);
    chk("ldmdb_s_wbsel", wsel_log[3], 32'd13);
    chk("ldmdb_s_r13", bank[13], 32'h1F4);
    chk("ldmdb_s_b17", bank[17], 32'h5555_0011);
    chk("ldmdb_s_b18", bank[18], 32'h5555_0012);

    // LDMIA r1 with base in list: loaded value wins, no WB cycle
    clear_bank();
    use_fixed = 1'b1; fixed_rdata = 32'h0000_DEAD;
    start_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'b10000, 4'd1, 32'h300, 16'h0006);
    run_op(0, 0, 0);
    chk("ldmia_nwr", 32'(wsel_log.size()), 32'd2);
    chk("ldmia_r1", bank[1], 32'h0000_DEAD);
    chk("ldmia_r2", bank[2], 32'h0000_DEAD);
    chk("ldmia_donecyc", 32'(done_cyc), 32'd4);
    use_fixed = 1'b0;

    // Empty list: straight to DONE, no memory or bank activity
    start_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'b10000, 4'd0, 32'h40, 16'h0000);
    run_op(0, 0, 0);
    chk("empty_nreq", 32'(addr_log.size()), 32'd0);
    chk("empty_nwr", 32'(wsel_log.size()), 32'd0);
    chk("empty_donecyc", 32'(done_cyc), 32'd1);
    @(negedge clk);
    chk("empty_idle", {30'b0, busy, done}, 32'd0);

    // STMIB r5, list r0..r7, slow memory, reset after the 4th word
    start_op(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'b10000, 4'd5, 32'h400, 16'h00FF);
    run_op(3, 4, 0);
    chk("stmib_nwords", 32'(addr_log.size()), 32'd4);
    chk("stmib_a0", addr_log[0], 32'h404);
    chk("stmib_a3", addr_log[3], 32'h410);
    chk("stmib_wd3", wdata_log[3], 32'hA000_0003);
    reset = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("abort_rst_ctrl", {27'b0, mem_req, mem_we, wr_en, busy, done}, 32'd0);
    chk("abort_rst_data", mem_addr | mem_wdata | wr_data, 32'd0);
    reset = 1'b0;
    done_cnt = 0;
    wsel_log.delete();
    begin
      int act;
      act = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (mem_req || wr_en || busy || done) act++;
      end
      chk("abort_rst_quiet", 32'(act), 32'd0);
    end

`ifdef MEM_ABORT_EN
    // LDMIB with abort on word 2: only word 1 written, no WB
    clear_bank();
    start_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'b10000, 4'd5, 32'h400, 16'h00FF);
    run_op(0, 0, 2);
    chk("memab_nwr", 32'(wsel_log.size()), 32'd1);
    chk("memab_ws0", wsel_log[0], 32'd0);
    chk("memab_wd0", wdat_log[0], 32'hC000_0404);
    chk("memab_flag", {31'b0, aborted_at_done}, 32'd1);
    chk("memab_r5", bank[5], 32'h5555_0005);
    start_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b10000, 4'd0, 32'h0, 16'h0000);
    @(negedge clk);
    start = 1'b0;
    chk("memab_clear", {31'b0, aborted}, 32'd0);
    repeat (2) @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
